// File: rtl/macro_wb_pkg.sv
// rtl/macro_wb_pkg.sv - shared states, register offsets and error codes for macro_wb_mux
package macro_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FWD,
    ST_RESP
  } state_t;

  localparam logic [31:0] REG_IO_SEL   = 32'h0000_0000;
  localparam logic [31:0] REG_LA_SEL   = 32'h0000_0004;
  localparam logic [31:0] REG_IRQ_MASK = 32'h0000_0008;
  localparam logic [31:0] REG_STATUS   = 32'h0000_000C;

  localparam logic [3:0] LOCAL_SLOT = 4'd15;
  localparam logic [3:0] SEL_NONE   = 4'd15;

  localparam logic [31:0] ERR_TIMEOUT  = 32'hDEAD_0000;
  localparam logic [31:0] ERR_UNMAPPED = 32'hBADA_DD00;

endpackage

// File: rtl/macro_wb_mux_out.sv
// rtl/macro_wb_mux_out.sv - registered select-or-default mux over N packed lanes
module macro_out_mux #(
  parameter int           W       = 38,
  parameter int           N       = 3,
  parameter logic [W-1:0] DEFAULT = '0
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [3:0]     i_sel,
  input  logic [W*N-1:0] i_data,
  output logic [W-1:0]   o_data
);

  logic [W-1:0] r_data;
  logic [W-1:0] w_next;

  // any select value without a matching lane falls through to DEFAULT
  always_comb begin
    w_next = DEFAULT;
    for (int i = 0; i < N; i++) begin
      if (i_sel == i[3:0]) w_next = i_data[i*W +: W];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_data <= DEFAULT;
    else       r_data <= w_next;
  end

  assign o_data = r_data;

endmodule

// File: rtl/macro_wb_mux.sv
// rtl/macro_wb_mux.sv - Wishbone slot decoder/forwarder with local IO/LA/IRQ routing registers
module macro_wb_mux
  import macro_wb_pkg::*;
#(
  parameter int N_MACROS = 3,
  parameter int SLOT_LSB = 20,
  parameter int TIMEOUT  = 255,
  parameter int IO_W     = 38
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       wbs_stb_i,
  input  logic                       wbs_cyc_i,
  input  logic                       wbs_we_i,
  input  logic [3:0]                 wbs_sel_i,
  input  logic [31:0]                wbs_dat_i,
  input  logic [31:0]                wbs_adr_i,
  output logic                       wbs_ack_o,
  output logic [31:0]                wbs_dat_o,
  output logic [N_MACROS-1:0]        m_stb_o,
  output logic [N_MACROS-1:0]        m_cyc_o,
  output logic                       m_we_o,
  output logic [3:0]                 m_sel_o,
  output logic [31:0]                m_dat_o,
  output logic [31:0]                m_adr_o,
  input  logic [N_MACROS-1:0]        m_ack_i,
  input  logic [32*N_MACROS-1:0]     m_dat_i,
  input  logic [IO_W*N_MACROS-1:0]   m_io_out_i,
  input  logic [IO_W*N_MACROS-1:0]   m_io_oeb_i,
  input  logic [128*N_MACROS-1:0]    m_la_out_i,
  input  logic [3*N_MACROS-1:0]      m_irq_i,
  output logic [IO_W-1:0]            io_out,
  output logic [IO_W-1:0]            io_oeb,
  output logic [127:0]               la_data_out,
  output logic [2:0]                 user_irq
);

  localparam int          CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int          MW       = 3 * N_MACROS;
  localparam int          MWB      = (MW < 32) ? MW : 32;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [3:0]  N_SLOT   = 4'(N_MACROS);
  localparam logic [31:0] OFF_MASK = (32'd1 << SLOT_LSB) - 32'd1;

  state_t                r_state, w_state_next;
  logic [3:0]            r_slot, w_slot_next;
  logic [CW-1:0]         r_cnt, w_cnt_next;
  logic                  r_ack;
  logic [31:0]           r_dat, w_dat_next;
  logic [N_MACROS-1:0]   r_stb, w_stb_next;
  logic                  r_we;
  logic [3:0]            r_sel;
  logic [31:0]           r_mdat, r_madr;
  logic [3:0]            r_io_sel, w_io_sel_next;
  logic [3:0]            r_la_sel, w_la_sel_next;
  logic [MW-1:0]         r_irq_mask, w_mask_next;
  logic                  r_to, w_to_next;
  logic [3:0]            r_to_slot, w_to_slot_next;
  logic [2:0]            r_irq, w_irq;
  logic                  w_capture;

  logic [3:0]            w_slot;
  logic [31:0]           w_off;
  logic                  w_req;
  logic                  w_ack;
  logic [31:0]           w_mdat;
  logic [31:0]           w_local_rdata;
  logic [MW-1:0]         w_irq_m;

  assign w_slot = wbs_adr_i[SLOT_LSB+3:SLOT_LSB];
  assign w_off  = wbs_adr_i & OFF_MASK;
  assign w_req  = wbs_cyc_i & wbs_stb_i;

  always_comb begin
    w_ack  = 1'b0;
    w_mdat = '0;
    for (int i = 0; i < N_MACROS; i++) begin
      if (r_slot == i[3:0]) begin
        w_ack  = m_ack_i[i];
        w_mdat = m_dat_i[32*i +: 32];
      end
    end
  end

  always_comb begin
    w_local_rdata = '0;
    case (w_off)
      REG_IO_SEL:   w_local_rdata = {28'd0, r_io_sel};
      REG_LA_SEL:   w_local_rdata = {28'd0, r_la_sel};
      REG_IRQ_MASK: for (int b = 0; b < MWB; b++) w_local_rdata[b] = r_irq_mask[b];
      REG_STATUS:   w_local_rdata = {24'd0, r_to_slot, 3'd0, r_to};
      default:      w_local_rdata = '0;
    endcase
  end

  always_comb begin
    w_state_next   = r_state;
    w_slot_next    = r_slot;
    w_cnt_next     = r_cnt;
    w_dat_next     = r_dat;
    w_io_sel_next  = r_io_sel;
    w_la_sel_next  = r_la_sel;
    w_mask_next    = r_irq_mask;
    w_to_next      = r_to;
    w_to_slot_next = r_to_slot;
    w_capture      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_slot_next = w_slot;
          if (w_slot < N_SLOT) begin
            w_state_next = ST_FWD;
            w_cnt_next   = '0;
            w_capture    = 1'b1;
          end else begin
            w_state_next = ST_RESP;
            if (w_slot == LOCAL_SLOT) begin
              w_dat_next = w_local_rdata;
              if (wbs_we_i) begin
                case (w_off)
                  REG_IO_SEL: if (wbs_sel_i[0]) w_io_sel_next = wbs_dat_i[3:0];
                  REG_LA_SEL: if (wbs_sel_i[0]) w_la_sel_next = wbs_dat_i[3:0];
                  REG_IRQ_MASK:
                    for (int b = 0; b < MWB; b++) begin
                      if (wbs_sel_i[b/8]) w_mask_next[b] = wbs_dat_i[b];
                    end
                  REG_STATUS: if (wbs_sel_i[0] && wbs_dat_i[0]) w_to_next = 1'b0;
                  default: ;
                endcase
              end
            end else begin
              w_dat_next = ERR_UNMAPPED;
            end
          end
        end
      end
      ST_FWD: begin
        // an ack arriving on the last counted cycle still beats the timeout
        if (w_ack) begin
          w_state_next = ST_RESP;
          w_dat_next   = w_mdat;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next   = ST_RESP;
          w_dat_next     = ERR_TIMEOUT | {28'd0, r_slot};
          w_to_next      = 1'b1;
          w_to_slot_next = r_slot;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_RESP: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < N_MACROS; i++) begin
      w_stb_next[i] = (w_state_next == ST_FWD) && (w_slot_next == i[3:0]);
    end
  end

  assign w_irq_m = m_irq_i & r_irq_mask;

  always_comb begin
    w_irq = '0;
    for (int i = 0; i < N_MACROS; i++) w_irq = w_irq | w_irq_m[3*i +: 3];
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state    <= ST_IDLE;
      r_slot     <= '0;
      r_cnt      <= '0;
      r_ack      <= 1'b0;
      r_dat      <= '0;
      r_stb      <= '0;
      r_we       <= 1'b0;
      r_sel      <= '0;
      r_mdat     <= '0;
      r_madr     <= '0;
      r_io_sel   <= SEL_NONE;
      r_la_sel   <= SEL_NONE;
      r_irq_mask <= '0;
      r_to       <= 1'b0;
      r_to_slot  <= '0;
      r_irq      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_slot     <= w_slot_next;
      r_cnt      <= w_cnt_next;
      r_ack      <= (w_state_next == ST_RESP);
      r_dat      <= w_dat_next;
      r_stb      <= w_stb_next;
      r_io_sel   <= w_io_sel_next;
      r_la_sel   <= w_la_sel_next;
      r_irq_mask <= w_mask_next;
      r_to       <= w_to_next;
      r_to_slot  <= w_to_slot_next;
      r_irq      <= w_irq;
      if (w_capture) begin
        r_we   <= wbs_we_i;
        r_sel  <= wbs_sel_i;
        r_mdat <= wbs_dat_i;
        r_madr <= wbs_adr_i;
      end
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign m_stb_o   = r_stb;
  assign m_cyc_o   = r_stb;
  assign m_we_o    = r_we;
  assign m_sel_o   = r_sel;
  assign m_dat_o   = r_mdat;
  assign m_adr_o   = r_madr;
  assign user_irq  = r_irq;

  macro_out_mux #(.W(IO_W), .N(N_MACROS), .DEFAULT('0)) u_io_out (
    .i_clk(wb_clk_i), .i_rst(wb_rst_i), .i_sel(r_io_sel), .i_data(m_io_out_i), .o_data(io_out)
  );

  macro_out_mux #(.W(IO_W), .N(N_MACROS), .DEFAULT({IO_W{1'b1}})) u_io_oeb (
    .i_clk(wb_clk_i), .i_rst(wb_rst_i), .i_sel(r_io_sel), .i_data(m_io_oeb_i), .o_data(io_oeb)
  );

  macro_out_mux #(.W(128), .N(N_MACROS), .DEFAULT('0)) u_la (
    .i_clk(wb_clk_i), .i_rst(wb_rst_i), .i_sel(r_la_sel), .i_data(m_la_out_i), .o_data(la_data_out)
  );

endmodule

// File: tb/tb_macro_wb_mux.sv
// tb/tb_macro_wb_mux.sv - directed and randomized checks of macro_wb_mux against a behavioural model
module tb_macro_wb_mux;

  localparam int N  = 3;
  localparam int TO = 8;
  localparam int IW = 38;

  logic            clk = 1'b0;
  logic            rst;
  logic            stb, cyc, we;
  logic [3:0]      sel;
  logic [31:0]     dat_i, adr;
  logic            ack_o;
  logic [31:0]     dat_o;
  logic [N-1:0]    m_stb, m_cyc;
  logic            m_we;
  logic [3:0]      m_sel;
  logic [31:0]     m_dat, m_adr;
  logic [N-1:0]    m_ack;
  logic [32*N-1:0] m_dat_i;
  logic [IW*N-1:0] m_io_out, m_io_oeb;
  logic [128*N-1:0] m_la;
  logic [3*N-1:0]  m_irq;
  logic [IW-1:0]   io_out, io_oeb;
  logic [127:0]    la_out;
  logic [2:0]      user_irq;

  logic [31:0]     mdat[N];
  logic [IW-1:0]   io_vals[N], oeb_vals[N];
  logic [127:0]    la_vals[N];

  int tests = 0;
  int fails = 0;

  logic [31:0] cap_adr, cap_dat;
  logic        cap_we;
  logic        model_to;
  logic [3:0]  model_to_slot;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      m_dat_i[32*i +: 32]   = mdat[i];
      m_io_out[IW*i +: IW]  = io_vals[i];
      m_io_oeb[IW*i +: IW]  = oeb_vals[i];
      m_la[128*i +: 128]    = la_vals[i];
    end
  end

  macro_wb_mux #(.N_MACROS(N), .SLOT_LSB(20), .TIMEOUT(TO), .IO_W(IW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack_o), .wbs_dat_o(dat_o),
    .m_stb_o(m_stb), .m_cyc_o(m_cyc), .m_we_o(m_we), .m_sel_o(m_sel),
    .m_dat_o(m_dat), .m_adr_o(m_adr), .m_ack_i(m_ack), .m_dat_i(m_dat_i),
    .m_io_out_i(m_io_out), .m_io_oeb_i(m_io_oeb), .m_la_out_i(m_la), .m_irq_i(m_irq),
    .io_out(io_out), .io_oeb(io_oeb), .la_data_out(la_out), .user_irq(user_irq)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One host transaction; the addressed macro acks in strobe cycle ack_j (0 = first).
  task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] s, input int ack_j,
                        output logic [31:0] rd, output int lat, output bit stb_bad);
    int slot, j;
    slot = int'(a[23:20]);
    @(negedge clk);
    adr = a; we = w; dat_i = d; sel = s; stb = 1'b1; cyc = 1'b1;
    lat = -1; j = 0; stb_bad = 1'b0; rd = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      m_ack = '0;
      if (ack_o) begin
        lat = n;
        rd  = dat_o;
        break;
      end
      if (m_stb !== m_cyc) stb_bad = 1'b1;
      if (m_stb != '0) begin
        if (slot >= N || m_stb !== N'(1 << slot)) stb_bad = 1'b1;
        if (j == 0) begin
          cap_adr = m_adr; cap_dat = m_dat; cap_we = m_we;
        end
        if (slot < N && j == ack_j) m_ack[slot] = 1'b1;
        j++;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic reg_wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s, input string tag);
    logic [31:0] rd; int lat; bit bad;
    access(32'h00F0_0000 | off, 1'b1, d, s, 0, rd, lat, bad);
    chk({tag, "_lat"}, lat, 1);
  endtask

  task automatic reg_rd(input logic [31:0] off, input string tag, output logic [31:0] rd);
    int lat; bit bad;
    access(32'h00F0_0000 | off, 1'b0, 32'h0, 4'hF, 0, rd, lat, bad);
    chk({tag, "_lat"}, lat, 1);
  endtask

  initial begin
    logic [31:0] rd, a, exp_dat;
    int lat, slot, aj, exp_lat;
    bit bad, ack_seen;
    logic [8:0] mask, irq;
    logic [2:0] exp_irq;

    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = '0; dat_i = '0; adr = '0;
    m_ack = '0; m_irq = '1;
    model_to = 1'b0; model_to_slot = '0;
    for (int i = 0; i < N; i++) begin
      mdat[i]     = $urandom;
      io_vals[i]  = IW'({$urandom, $urandom}) | 38'd1;
      oeb_vals[i] = IW'({$urandom, $urandom}) & ~38'd1;
      la_vals[i]  = {$urandom, $urandom, $urandom, $urandom} | 128'd1;
    end
    repeat (3) @(negedge clk);
    chk("rst_ack", ack_o, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_stb", {m_stb, m_cyc}, 0);
    chk("rst_io_out", io_out, 0);
    chk("rst_io_oeb", io_oeb, {IW{1'b1}});
    chk("rst_la", la_out, 0);
    chk("rst_irq", user_irq, 0);
    rst = 1'b0; m_irq = '0;

    reg_rd(32'h0, "rst_io_sel", rd);   chk("rst_io_sel", rd, 15);
    reg_rd(32'hC, "rst_status", rd);   chk("rst_status", rd, 0);

    mdat[1] = 32'h1234_5678;
    access(32'h0010_0004, 1'b0, 32'h0, 4'hF, 0, rd, lat, bad);
    chk("fwd_rd_dat", rd, 32'h1234_5678);
    chk("fwd_rd_lat", lat, 2);
    chk("fwd_rd_onehot", bad, 0);
    chk("fwd_rd_adr", cap_adr, 32'h0010_0004);

    for (int k = 0; k < 8; k++) begin
      slot = $urandom_range(0, N - 1);
      aj   = $urandom_range(0, 10);
      a    = ($urandom & 32'hFF0F_FFFC) | (32'(slot) << 20);
      mdat[slot] = $urandom;
      exp_dat = $urandom;
      we = 1'b0;
      if (aj <= TO - 1) begin
        exp_lat = aj + 2;
        rd      = mdat[slot];
      end else begin
        exp_lat = TO + 1;
        rd      = 32'hDEAD_0000 | 32'(slot);
        model_to = 1'b1; model_to_slot = 4'(slot);
      end
      exp_dat = rd;
      access(a, k[0], 32'hA5A5_0000 + 32'(k), 4'hF, aj, rd, lat, bad);
      chk("rnd_dat", rd, exp_dat);
      chk("rnd_lat", lat, exp_lat);
      chk("rnd_onehot", bad, 0);
      chk("rnd_cap", {cap_adr, cap_dat, cap_we}, {a, 32'hA5A5_0000 + 32'(k), k[0]});
    end
    reg_rd(32'hC, "rnd_status", rd);
    chk("rnd_status", rd, {24'd0, model_to_slot, 3'd0, model_to});

    access(32'h0000_0000, 1'b0, 32'h0, 4'hF, 100, rd, lat, bad);
    chk("to_lat", lat, TO + 1);
    chk("to_dat", rd, 32'hDEAD_0000);
    reg_rd(32'hC, "to_status", rd);    chk("to_status", rd, 32'h01);
    reg_wr(32'hC, 32'h1, 4'h1, "to_clr");
    reg_rd(32'hC, "to_status2", rd);   chk("to_status2", rd, 32'h00);

    reg_wr(32'h0, 32'h2, 4'hF, "io_sel2");
    @(negedge clk);
    chk("io_out_m2", io_out, io_vals[2]);
    chk("io_oeb_m2", io_oeb, oeb_vals[2]);
    io_vals[2] = IW'({$urandom, $urandom});
    @(negedge clk);
    chk("io_follow", io_out, io_vals[2]);
    reg_wr(32'h0, 32'h0, 4'h0, "io_nosel");
    reg_rd(32'h0, "io_nosel_rd", rd);  chk("io_nosel_rd", rd, 2);
    reg_wr(32'h0, 32'h7, 4'hF, "io_sel7");
    @(negedge clk);
    chk("io_out_none", io_out, 0);
    chk("io_oeb_none", io_oeb, {IW{1'b1}});
    reg_wr(32'h4, 32'h1, 4'hF, "la_sel1");
    @(negedge clk);
    chk("la_m1", la_out, la_vals[1]);

    reg_wr(32'h8, 32'h10, 4'hF, "irq_mask");
    m_irq = 9'h010;
    @(negedge clk);
    chk("irq_pass", user_irq, 3'b010);
    m_irq = 9'h002;
    @(negedge clk);
    chk("irq_block", user_irq, 3'b000);
    for (int k = 0; k < 4; k++) begin
      mask = 9'($urandom);
      reg_wr(32'h8, {23'd0, mask}, 4'hF, "rnd_mask");
      reg_rd(32'h8, "rnd_mask_rd", rd);
      chk("rnd_mask_rd", rd, {23'd0, mask});
      irq = 9'($urandom);
      m_irq = irq;
      exp_irq = '0;
      for (int b = 0; b < 3; b++)
        for (int m = 0; m < N; m++)
          if (irq[3*m + b] && mask[3*m + b]) exp_irq[b] = 1'b1;
      @(negedge clk);
      chk("rnd_irq", user_irq, exp_irq);
    end
    m_irq = '0;

    access(32'h0050_0000, 1'b0, 32'h0, 4'hF, 0, rd, lat, bad);
    chk("unmap_dat", rd, 32'hBADA_DD00);
    chk("unmap_lat", lat, 1);
    chk("unmap_nostb", bad, 0);
    access(32'h0050_0000, 1'b1, 32'h1, 4'hF, 0, rd, lat, bad);
    chk("unmap_wr_lat", lat, 1);
    reg_rd(32'h0, "unmap_wr_rd", rd);  chk("unmap_wr_rd", rd, 7);

    @(negedge clk);
    adr = 32'h0020_0000; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_fwd_stb", m_stb, 3'b100);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_stb", {m_stb, m_cyc}, 0);
    chk("abort_ack", ack_o, 0);
    stb = 1'b0; cyc = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ack_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (ack_o) ack_seen = 1'b1;
    end
    chk("abort_no_ack", ack_seen, 0);
    chk("abort_io_oeb", io_oeb, {IW{1'b1}});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/macro_wb_mux.md
# macro_wb_mux

Parametrised successor to the multi-macro user wrapper. It connects N user macros to the single Caravel Wishbone slave port, IO pads, logic analyser and IRQ lines through address-decoded arbitration rather than shared wiring. A registered forwarding FSM routes each bus transaction to one macro and bounds it with a timeout. A local register bank selects which macro owns the IO pads and the LA outputs, and masks per-macro interrupts. It sits directly inside user_project_wrapper, between the harness and the macro instances.

## Interface

Parameters:
- N_MACROS, 3: number of attached macros (1–15).
- SLOT_LSB, 20: lowest address bit of the 4-bit slot field `wbs_adr_i[SLOT_LSB+3:SLOT_LSB]`.
- TIMEOUT, 255: cycles the FSM waits for a macro ack before aborting.
- IO_W, 38: pad count.

Ports (clock and reset first):
- wb_clk_i, in, 1: sole clock.
- wb_rst_i, in, 1: reset, synchronous and active-high.
- wbs_stb_i / wbs_cyc_i / wbs_we_i, in, 1 each: host Wishbone controls.
- wbs_sel_i, in, 4: byte enables.
- wbs_dat_i / wbs_adr_i, in, 32 each: host write data and address.
- wbs_ack_o, out, 1: registered ack.
- wbs_dat_o, out, 32: registered read data.
- m_stb_o / m_cyc_o, out, N_MACROS: per-macro strobe and cycle, one-hot.
- m_we_o, m_sel_o, m_dat_o, m_adr_o, out, 1/4/32/32: shared, registered copies of the host request.
- m_ack_i, in, N_MACROS: per-macro ack.
- m_dat_i, in, 32·N_MACROS: per-macro read data, flattened.
- m_io_out_i / m_io_oeb_i, in, IO_W·N_MACROS: per-macro pad drive.
- m_la_out_i, in, 128·N_MACROS: per-macro LA outputs.
- m_irq_i, in, 3·N_MACROS: per-macro IRQs.
- io_out / io_oeb, out, IO_W each: pad outputs of the owning macro.
- la_data_out, out, 128: LA outputs of the owning macro.
- user_irq, out, 3: masked OR of the macro IRQs.

## Operation

**Address decode**
- slot < N_MACROS: forwarded to macro[slot].
- slot == 15: local register bank.
- Any other slot: unmapped.

**FSM states: IDLE, FWD, RESP.**
- IDLE, cyc&stb, macro slot: latch the request and the slot, go to FWD.
- IDLE, cyc&stb, local or unmapped slot: perform the register access, load the response, go to RESP.
- FWD: assert m_cyc_o/m_stb_o for the latched slot and increment the timeout counter from 0.
  - m_ack_i[slot]=1: latch m_dat_i for that slot, go to RESP.
  - Counter reaches TIMEOUT-1 with no ack: load data 32'hDEAD_0000|slot, set the sticky TO flag, record TO_SLOT, go to RESP.
  - Ack and expiry in the same cycle: the ack wins.
- RESP: wbs_ack_o=1 for exactly one cycle, then return to IDLE. A new request is accepted no earlier than the cycle after RESP.
- Unmapped read returns 32'hBADA_DD00. Unmapped write is acked and has no effect.

**Local registers** (byte offset within slot 15; writes honour wbs_sel_i)
- 0x00 IO_SEL[3:0]: owner of io_out/io_oeb. Reset value 15 = none.
- 0x04 LA_SEL[3:0]: owner of la_data_out. Reset value 15 = none.
- 0x08 IRQ_MASK[3·N_MACROS-1:0]: reset value 0.
- 0x0C STATUS: [0] = TO (write 1 to clear), [7:4] = TO_SLOT (read-only).
- Other offsets read 0.

**Output muxing**
- If IO_SEL ≥ N_MACROS: io_out=0 and io_oeb=all ones.
- If LA_SEL ≥ N_MACROS: la_data_out=0.
- user_irq[k] = OR over i of (m_irq_i[3i+k] & IRQ_MASK[3i+k]).

## Timing

- Reset values: state=IDLE, wbs_ack_o=0, wbs_dat_o=0, m_stb_o=m_cyc_o=0, io_out=0, io_oeb='1, la_data_out=0, user_irq=0, IO_SEL=LA_SEL=15, IRQ_MASK=0, STATUS=0.
- Reset asserted mid-transaction: the next edge returns the FSM to IDLE and drops m_stb_o/m_cyc_o. No ack is issued for the interrupted transaction.
- Forwarded access: m_stb_o rises 1 cycle after the host strobe is sampled. wbs_ack_o rises 1 cycle after m_ack_i. A macro that acks in its first strobe cycle gives a host-visible ack 2 cycles after the request is sampled.
- Local or unmapped access: wbs_ack_o is asserted 1 cycle after the request is sampled.
- Timeout: wbs_ack_o is asserted TIMEOUT+1 cycles after the request is sampled.
- io_out, io_oeb, la_data_out and user_irq are registered: 1 cycle from the input or select change to the output.
- A write to IO_SEL takes effect on the pads 2 cycles after the write is sampled.

## Structure

- Package macro_wb_pkg holds:
  - the state enum;
  - register offsets 0x00/0x04/0x08/0x0C;
  - LOCAL_SLOT=15 and SEL_NONE=15;
  - error constants 32'hDEAD_0000 and 32'hBADA_DD00.
- Sub-module macro_out_mux, parametrised by width and N: a registered select-or-default mux. It is instantiated once for io_out, once for io_oeb (default all ones) and once for la_data_out (default 0).

## Test plan

- **Forwarded read:** read slot 1 at 0x0010_0004; macro 1 acks on its first strobe cycle with 0x1234_5678. Required: wbs_dat_o=0x1234_5678, wbs_ack_o 2 cycles after the request, m_stb_o stays one-hot 3'b010.
- **Timeout:** TIMEOUT=8, macro 0 never acks. Required: ack at cycle 9 with data 0xDEAD_0000; a STATUS read returns 0x01. Writing 1 to bit 0 of STATUS clears it, and a re-read returns 0x00.
- **IO ownership:** write IO_SEL=2. Required: io_out equals macro 2's m_io_out_i 2 cycles after the write. Write IO_SEL=7 (≥ N_MACROS). Required: io_oeb all ones, io_out all zeros.
- **IRQ masking:** write IRQ_MASK=9'b000_010_000 and pulse m_irq_i[4]. Required: user_irq=3'b010 one cycle later. m_irq_i[1] must not propagate.
- **Unmapped and reset abort:** a read of slot 5 returns 0xBADA_DD00 with a 1-cycle ack. Asserting wb_rst_i during a FWD wait must clear m_stb_o and must produce no ack.
